iob_ram_2p_pipe: RTL and testbench
==================================

// Module: iob_ram_2p_pipe
// PURPOSE
//   Simple dual-port RAM (one write port, one read port, one clock) with byte-write strobes,
//   a configurable read-latency pipeline with a valid flag, and selectable read-during-write
//   collision policy. An optional post-reset zero-fill walks the array before ports go ready.
//   It replaces the plain two-port RAM as the buffer primitive in stream and DMA blocks.
// PARAMETERS
//   DATA_W      32  data width in bits; must be a multiple of 8
//   ADDR_W      10  address width; depth = 2**ADDR_W words
//   READ_LAT    1   read latency in cycles, legal 1..4
//   WRITE_FIRST 1   1: same-cycle same-address read returns new data; 0: returns old data
//   INIT_ZERO   1   1: zero-fill the whole array after reset; 0: no fill, contents undefined
// PORTS
//   clk_i      in   1         clock, rising edge
//   arst_n_i   in   1         asynchronous reset, active low
//   w_en_i     in   1         write request
//   w_strb_i   in   DATA_W/8  byte write enables; bit k covers w_data_i[8k+7:8k]
//   w_addr_i   in   ADDR_W    write address
//   w_data_i   in   DATA_W    write data
//   w_ready_o  out  1         write port accepting requests
//   r_en_i     in   1         read request
//   r_addr_i   in   ADDR_W    read address
//   r_data_o   out  DATA_W    read data; held between reads
//   r_valid_o  out  1         one-cycle pulse: r_data_o carries a new read result
//   r_ready_o  out  1         read port accepting requests
// BEHAVIOUR
//   - Reset (arst_n_i=0): w_ready_o=0, r_ready_o=0, r_valid_o=0, r_data_o=0, all pipeline
//     valid bits cleared, FSM -> INIT (INIT_ZERO=1) or IDLE (INIT_ZERO=0). Array not reset.
//   - FSM INIT: an ADDR_W-bit counter starting at 0 writes all-zero words, one per cycle.
//     After address 2**ADDR_W-1 is written (2**ADDR_W cycles), go to RUN. Readies are low.
//   - FSM IDLE (INIT_ZERO=0 only): held for one cycle after reset release, then RUN.
//   - FSM RUN: w_ready_o=r_ready_o=1 permanently. RUN is left only by reset.
//   - Reset asserted in any state, including mid-INIT, aborts the fill and restarts from
//     the reset state. Pending reads are discarded with no r_valid_o pulse.
//   - Write accepted when w_en_i & w_ready_o. Only bytes with w_strb_i[k]=1 update at the
//     clock edge. w_strb_i=0 is a legal no-op. Requests while not ready are ignored.
//   - Read accepted when r_en_i & r_ready_o. The array is sampled at the accepting edge.
//     r_data_o updates and r_valid_o=1 exactly READ_LAT cycles after acceptance.
//   - Back-to-back reads every cycle give one result per cycle, in order. No bubbles.
//   - With no read accepted, r_valid_o=0 and r_data_o keeps its last value.
//   - Collision (write and read accepted, same address, same edge):
//     WRITE_FIRST=1: result = w_data_i bytes where strobe=1, old bytes elsewhere.
//     WRITE_FIRST=0: result = old word.
//   - Writes after the accepting edge never change an in-flight read result.
//   - Address wrap: none. Every address 0..2**ADDR_W-1 is independent.
// TESTING  (DATA_W=32, ADDR_W=10 unless stated)
//   1 INIT_ZERO=1: release reset; ready stays 0 for 1024 cycles, then 1. Read all 1024 words
//     -> every r_data_o=0, one r_valid_o pulse per read.
//   2 Write addr i with i+32, strobe 4'hF, i=0..1023. Back-to-back reads, READ_LAT=1 and
//     again with READ_LAT=3 -> data i+32 exactly READ_LAT cycles after each request.
//   3 Addr 5 holds 32'h11223344. Write 32'hAABBCCDD with strb 4'b0101 -> read returns
//     32'h11BB33DD.
//   4 Collision at addr 7 (old 32'h0, new 32'hDEADBEEF, strb 4'hF): WRITE_FIRST=1 ->
//     32'hDEADBEEF; WRITE_FIRST=0 -> 32'h0. Next read of addr 7 -> 32'hDEADBEEF both modes.
//   5 Assert arst_n_i at init count 500, release -> readies low for a full 1024 cycles
//     again. Read any address -> 0.
//   6 Reset with a READ_LAT=3 read in flight -> no r_valid_o pulse, r_data_o=0.

Source files
------------

// File: rtl/iob_ram_2p_pipe.sv
// Simple dual-port RAM with byte strobes, a READ_LAT-deep read pipeline with valid flag,
// selectable read-during-write policy and an optional post-reset zero-fill.
module iob_ram_2p_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int READ_LAT    = 1,
    parameter int WRITE_FIRST = 1,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  w_en_i,
    input  logic [DATA_W/8-1:0]   w_strb_i,
    input  logic [ADDR_W-1:0]     w_addr_i,
    input  logic [DATA_W-1:0]     w_data_i,
    output logic                  w_ready_o,
    input  logic                  r_en_i,
    input  logic [ADDR_W-1:0]     r_addr_i,
    output logic [DATA_W-1:0]     r_data_o,
    output logic                  r_valid_o,
    output logic                  r_ready_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   init_cnt;
    logic [ADDR_W-1:0]   init_cnt_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                ready;
    logic                fill;
    logic                w_acc;
    logic                r_acc;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   stage_data [READ_LAT];
    logic [READ_LAT-1:0] stage_valid;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state    <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            ST_INIT: begin
                init_cnt_next = init_cnt + 1'b1;
                if (init_cnt == '1) begin
                    state_next = ST_RUN;
                end
            end
            ST_IDLE: state_next = ST_RUN;
            default: ;
        endcase
    end

    assign ready     = (state == ST_RUN);
    assign fill      = (state == ST_INIT);
    assign w_ready_o = ready;
    assign r_ready_o = ready;
    assign w_acc     = w_en_i & ready;
    assign r_acc     = r_en_i & ready;

    // Word as it will look after this edge's write; only used to forward a collision.
    always_comb begin
        wr_word = mem[w_addr_i];
        for (int k = 0; k < NB; k++) begin
            if (w_strb_i[k]) begin
                wr_word[8*k +: 8] = w_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[r_addr_i];
        if ((WRITE_FIRST != 0) && w_acc && (w_addr_i == r_addr_i)) begin
            rd_word = wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            mem[init_cnt] <= '0;
        end else if (w_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (w_strb_i[k]) begin
                    mem[w_addr_i][8*k +: 8] <= w_data_i[8*k +: 8];
                end
            end
        end
    end

    // Each stage only loads when the stage before it is valid, so the last stage holds its data.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            stage_valid <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            stage_valid[0] <= r_acc;
            if (r_acc) begin
                stage_data[0] <= rd_word;
            end
            for (int k = 1; k < READ_LAT; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                if (stage_valid[k-1]) begin
                    stage_data[k] <= stage_data[k-1];
                end
            end
        end
    end

    assign r_data_o  = stage_data[READ_LAT-1];
    assign r_valid_o = stage_valid[READ_LAT-1];

endmodule

// File: tb/tb_iob_ram_2p_pipe.sv
// Directed bench for iob_ram_2p_pipe: three instances share stimulus
// (a: lat1 write-first, b: lat3 read-first, c: lat2 no zero-fill, 16 words).
module tb_iob_ram_2p_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_en;
    logic [3:0]  w_strb;
    logic [9:0]  w_addr;
    logic [31:0] w_data;
    logic        r_en;
    logic [9:0]  r_addr;

    logic [31:0] a_rdata, b_rdata, c_rdata;
    logic        a_rvalid, b_rvalid, c_rvalid;
    logic        a_wready, b_wready, c_wready;
    logic        a_rready, b_rready, c_rready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iob_ram_2p_pipe #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .WRITE_FIRST(1), .INIT_ZERO(1)) dut_a (
        .clk_i(clk), .arst_n_i(rst_n),
        .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data), .w_ready_o(a_wready),
        .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(a_rdata), .r_valid_o(a_rvalid), .r_ready_o(a_rready)
    );

    iob_ram_2p_pipe #(.DATA_W(32), .ADDR_W(10), .READ_LAT(3), .WRITE_FIRST(0), .INIT_ZERO(1)) dut_b (
        .clk_i(clk), .arst_n_i(rst_n),
        .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data), .w_ready_o(b_wready),
        .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(b_rdata), .r_valid_o(b_rvalid), .r_ready_o(b_rready)
    );

    iob_ram_2p_pipe #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2), .WRITE_FIRST(1), .INIT_ZERO(0)) dut_c (
        .clk_i(clk), .arst_n_i(rst_n),
        .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr[3:0]), .w_data_i(w_data), .w_ready_o(c_wready),
        .r_en_i(r_en), .r_addr_i(r_addr[3:0]), .r_data_o(c_rdata), .r_valid_o(c_rvalid), .r_ready_o(c_rready)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!a_wready && cnt < 2000);
        n_checks++;
        if (cnt !== 1024) begin
            n_errors++;
            $display("[TB] FAIL %s_ready_delay got %0d cycles expected 1024", name, cnt);
        end
        n_checks++;
        if ({a_rready, b_wready, b_rready} !== 3'b111) begin
            n_errors++;
            $display("[TB] FAIL %s_ready_all got %b expected 111", name, {a_rready, b_wready, b_rready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; w_en = 1'b0; w_strb = 4'h0; w_addr = '0; w_data = '0; r_en = 1'b0; r_addr = '0;
        #23;
        n_checks++;
        if ({a_wready, a_rready, b_wready, b_rready, c_wready, c_rready} !== 6'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_ready got %b expected 000000",
                     {a_wready, a_rready, b_wready, b_rready, c_wready, c_rready});
        end
        n_checks++;
        if ({a_rvalid, b_rvalid, c_rvalid} !== 3'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_valid got %b expected 000", {a_rvalid, b_rvalid, c_rvalid});
        end
        n_checks++;
        if ((a_rdata | b_rdata | c_rdata) !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_data got %h/%h/%h expected 0", a_rdata, b_rdata, c_rdata);
        end
    endtask

    task automatic test_init_zero();
        int cnt;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        cnt = 1;
        n_checks++;
        if ({c_wready, c_rready} !== 2'b11) begin
            n_errors++;
            $display("[TB] FAIL idle_one_cycle got %b expected 11", {c_wready, c_rready});
        end
        n_checks++;
        if (a_wready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL init_ready_low got %b expected 0", a_wready);
        end
        while (!a_wready && cnt < 2000) begin
            step();
            cnt++;
        end
        n_checks++;
        if (cnt !== 1024) begin
            n_errors++;
            $display("[TB] FAIL init_ready_delay got %0d cycles expected 1024", cnt);
        end
        for (int t = 0; t < 1024 + 3; t++) begin
            r_en   = (t < 1024);
            r_addr = 10'(t);
            step();
            n_checks++;
            if (t < 1024) begin
                if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
                    n_errors++;
                    $display("[TB] FAIL init_read_a addr %0d got v=%b d=%h expected v=1 d=0", t, a_rvalid, a_rdata);
                end
            end else if (a_rvalid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL init_read_a_tail got v=%b expected 0", a_rvalid);
            end
            n_checks++;
            if (t >= 2 && t - 2 < 1024) begin
                if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin
                    n_errors++;
                    $display("[TB] FAIL init_read_b addr %0d got v=%b d=%h expected v=1 d=0", t - 2, b_rvalid, b_rdata);
                end
            end else if (b_rvalid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL init_read_b_edge t=%0d got v=%b expected 0", t, b_rvalid);
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 1024; i++) begin
            w_en = 1'b1; w_strb = 4'hF; w_addr = 10'(i); w_data = 32'(i + 32);
            step();
        end
        w_en = 1'b0;
        for (int t = 0; t < 1024 + 3; t++) begin
            r_en   = (t < 1024);
            r_addr = 10'(1023 - t);
            step();
            n_checks++;
            if (t < 1024) begin
                if (a_rvalid !== 1'b1 || a_rdata !== 32'(1023 - t + 32)) begin
                    n_errors++;
                    $display("[TB] FAIL b2b_read_a addr %0d got v=%b d=%h expected v=1 d=%h",
                             1023 - t, a_rvalid, a_rdata, 32'(1023 - t + 32));
                end
            end else if (a_rvalid !== 1'b0 || a_rdata !== 32'd32) begin
                n_errors++;
                $display("[TB] FAIL b2b_hold_a got v=%b d=%h expected v=0 d=00000020", a_rvalid, a_rdata);
            end
            n_checks++;
            if (t >= 2 && t - 2 < 1024) begin
                if (b_rvalid !== 1'b1 || b_rdata !== 32'(1023 - (t - 2) + 32)) begin
                    n_errors++;
                    $display("[TB] FAIL b2b_read_b addr %0d got v=%b d=%h expected v=1 d=%h",
                             1023 - (t - 2), b_rvalid, b_rdata, 32'(1023 - (t - 2) + 32));
                end
            end else if (b_rvalid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL b2b_read_b_edge t=%0d got v=%b expected 0", t, b_rvalid);
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_byte_strobe();
        w_en = 1'b1; w_strb = 4'hF; w_addr = 10'd5; w_data = 32'h11223344;
        step();
        w_strb = 4'b0101; w_data = 32'hAABBCCDD;
        step();
        w_en = 1'b1; w_strb = 4'h0; w_addr = 10'd5; w_data = 32'hFFFFFFFF;
        r_en = 1'b1; r_addr = 10'd5;
        step();
        w_en = 1'b0; r_en = 1'b0;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h11BB33DD) begin
            n_errors++;
            $display("[TB] FAIL strobe_a got v=%b d=%h expected v=1 d=11bb33dd", a_rvalid, a_rdata);
        end
        step();
        n_checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'h11BB33DD) begin
            n_errors++;
            $display("[TB] FAIL strobe_c got v=%b d=%h expected v=1 d=11bb33dd", c_rvalid, c_rdata);
        end
        n_checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'h11BB33DD) begin
            n_errors++;
            $display("[TB] FAIL strobe_hold_a got v=%b d=%h expected v=0 d=11bb33dd", a_rvalid, a_rdata);
        end
        step();
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h11BB33DD) begin
            n_errors++;
            $display("[TB] FAIL strobe_b got v=%b d=%h expected v=1 d=11bb33dd", b_rvalid, b_rdata);
        end
    endtask

    task automatic test_collision();
        w_en = 1'b1; w_strb = 4'hF; w_addr = 10'd7; w_data = 32'h0;
        step();
        w_data = 32'hDEADBEEF; r_en = 1'b1; r_addr = 10'd7;
        step();
        w_en = 1'b0;
        n_checks++;
        if (a_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL coll_wf_a got %h expected deadbeef", a_rdata);
        end
        step();
        r_en = 1'b0;
        n_checks++;
        if (a_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL coll_next_a got %h expected deadbeef", a_rdata);
        end
        step();
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL coll_rf_b got v=%b d=%h expected v=1 d=0", b_rvalid, b_rdata);
        end
        step();
        n_checks++;
        if (b_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL coll_next_b got %h expected deadbeef", b_rdata);
        end
        w_en = 1'b1; w_strb = 4'b0011; w_addr = 10'd7; w_data = 32'h12345678; r_en = 1'b1; r_addr = 10'd7;
        step();
        w_en = 1'b0; r_en = 1'b0;
        n_checks++;
        if (a_rdata !== 32'hDEAD5678) begin
            n_errors++;
            $display("[TB] FAIL coll_partial_a got %h expected dead5678", a_rdata);
        end
        step();
        step();
        n_checks++;
        if (b_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL coll_partial_b got %h expected deadbeef", b_rdata);
        end
    endtask

    task automatic test_inflight_write();
        r_en = 1'b1; r_addr = 10'd9;
        step();
        r_en = 1'b0;
        w_en = 1'b1; w_strb = 4'hF; w_addr = 10'd9; w_data = 32'hCAFEF00D;
        n_checks++;
        if (a_rdata !== 32'd41) begin
            n_errors++;
            $display("[TB] FAIL inflight_a got %h expected 00000029", a_rdata);
        end
        step();
        w_en = 1'b0;
        step();
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'd41) begin
            n_errors++;
            $display("[TB] FAIL inflight_b got v=%b d=%h expected v=1 d=00000029", b_rvalid, b_rdata);
        end
    endtask

    task automatic test_reset_mid_init();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (500) step();
        rst_n = 1'b0;
        n_checks++;
        if (a_wready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL mid_init_ready got %b expected 0", a_wready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");
        r_en = 1'b1; r_addr = 10'd1000;
        step();
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reinit_read_1000 got v=%b d=%h expected v=1 d=0", a_rvalid, a_rdata);
        end
        r_addr = 10'd5;
        step();
        r_en = 1'b0;
        n_checks++;
        if (a_rdata !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reinit_read_5 got %h expected 0", a_rdata);
        end
        step();
        step();
    endtask

    task automatic test_reset_inflight();
        logic seen;
        w_en = 1'b1; w_strb = 4'hF; w_addr = 10'd5; w_data = 32'h00000055;
        step();
        w_en = 1'b0; r_en = 1'b1; r_addr = 10'd5;
        step();
        r_en = 1'b0;
        rst_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | b_rvalid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL inflight_reset_valid got %b expected 0", seen);
        end
        n_checks++;
        if (b_rdata !== 32'h0 || a_rdata !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL inflight_reset_data got %h/%h expected 0", a_rdata, b_rdata);
        end
        rst_n = 1'b1;
        wait_init("post_reset");
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_back_to_back();
        test_byte_strobe();
        test_collision();
        test_inflight_write();
        test_reset_mid_init();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
